// File: rtl/fpu_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpu_request_arbiter_if
//   Request/response bus between a set of requesters (lanes/warps) and the
//   shared floating-point ALU arbiter. The package ahead of the interface holds
//   the ALU opcode type that the requesters, the arbiter and the ALU share.
//
//   Request side (one channel per requester, indexed 0..NUM_REQ-1):
//     req_valid   requester -> arbiter   request pending
//     req_ready   arbiter -> requester   one-hot accept
//     req_op1     requester -> arbiter   operand 1
//     req_op2     requester -> arbiter   operand 2
//     req_instr   requester -> arbiter   ALU opcode
//   Response side (single shared channel):
//     resp_valid  arbiter -> consumer    response pending
//     resp_ready  consumer -> arbiter    response accept
//     resp_id     arbiter -> consumer    index of the owning requester
//     resp_result arbiter -> consumer    captured ALU result
//     resp_cmp    arbiter -> consumer    captured ALU compare flag
//   Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
package fpu_arb_pkg;
    typedef enum logic [3:0] {
        FADD = 4'd0,
        FSUB = 4'd1,
        FMUL = 4'd2,
        FDIV = 4'd3,
        FEQ  = 4'd4,
        FLT  = 4'd5,
        FLE  = 4'd6
    } alu_instruction_t;
endpackage

interface fpu_request_arbiter_if
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][31:0]          req_op1;
    logic [NUM_REQ-1:0][31:0]          req_op2;
    alu_instruction_t [NUM_REQ-1:0]    req_instr;
    logic                              resp_valid;
    logic                              resp_ready;
    logic [IDW-1:0]                    resp_id;
    logic [31:0]                       resp_result;
    logic                              resp_cmp;

    modport master (
        output req_valid, req_op1, req_op2, req_instr, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_cmp
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_instr, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_cmp
    );
endinterface

// File: rtl/fpu_request_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_request_arbiter
//   Shares one combinational floating_alu among NUM_REQ requesters. A
//   round-robin pointer picks one pending request, the winning operands are
//   registered and held on the ALU inputs for a per-opcode number of cycles
//   (multicycle path), then the ALU output is captured and returned on a
//   single response channel tagged with the requester id.
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     bus         fpu_request_arbiter_if.slave (request + response channels)
//     alu_op1     registered operand 1 to the ALU
//     alu_op2     registered operand 2 to the ALU
//     alu_instr   registered opcode to the ALU
//     alu_result  ALU result (combinational from alu_*)
//     alu_cmp     ALU compare flag
//     busy        high whenever an operation is in flight or awaiting pickup
// ---------------------------------------------------------------------------
module fpu_request_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  MUL_CYCLES = 2,
    parameter int  DIV_CYCLES = 4,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpu_request_arbiter_if.slave  bus,
    output logic [31:0]           alu_op1,
    output logic [31:0]           alu_op2,
    output alu_instruction_t      alu_instr,
    input  logic [31:0]           alu_result,
    input  logic                  alu_cmp,
    output logic                  busy
);

    localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("fpu_request_arbiter: NUM_REQ must be >= 2");
    end
    if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
        $error("fpu_request_arbiter: MUL_CYCLES must be >= 1");
    end
    if (DIV_CYCLES < 1) begin : g_bad_div_cycles
        $error("fpu_request_arbiter: DIV_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       alu_op1_q, alu_op1_d;
    logic [31:0]       alu_op2_q, alu_op2_d;
    alu_instruction_t  alu_instr_q, alu_instr_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [31:0]       resp_result_q, resp_result_d;
    logic              resp_cmp_q, resp_cmp_d;
    logic              resp_valid_q, resp_valid_d;

    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    cand;
    logic              grant_found;
    logic [NUM_REQ-1:0] req_ready_c;

    // Remaining EXEC cycles after the first one; cnt counts down to zero.
    function automatic logic [CW-1:0] exec_count(input alu_instruction_t op);
        case (op)
            FMUL:    return CW'(MUL_CYCLES - 1);
            FDIV:    return CW'(DIV_CYCLES - 1);
            default: return '0;
        endcase
    endfunction

    // Round-robin search starting just after the last winner, so the most
    // recently served requester has the lowest priority next time.
    always_comb begin
        grant       = last_grant_q;
        cand        = last_grant_q;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_grant_q) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    // Next-state and datapath: IDLE accepts one request, EXEC holds the ALU
    // inputs for the opcode's latency, RESP holds the response until taken.
    // The RESP->IDLE cycle never grants, so peak rate is one op per L+2 cycles.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        alu_op1_d     = alu_op1_q;
        alu_op2_d     = alu_op2_q;
        alu_instr_d   = alu_instr_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_cmp_d    = resp_cmp_q;
        resp_valid_d  = resp_valid_q;
        req_ready_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant] = 1'b1;
                    alu_op1_d          = bus.req_op1[grant];
                    alu_op2_d          = bus.req_op2[grant];
                    alu_instr_d        = bus.req_instr[grant];
                    resp_id_d          = grant;
                    last_grant_d       = grant;
                    cnt_d              = exec_count(bus.req_instr[grant]);
                    state_d            = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    resp_result_d = alu_result;
                    resp_cmp_d    = alu_cmp;
                    resp_valid_d  = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            cnt_q         <= '0;
            alu_op1_q     <= '0;
            alu_op2_q     <= '0;
            alu_instr_q   <= alu_instruction_t'('0);
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_cmp_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            alu_op1_q     <= alu_op1_d;
            alu_op2_q     <= alu_op2_d;
            alu_instr_q   <= alu_instr_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_cmp_q    <= resp_cmp_d;
            resp_valid_q  <= resp_valid_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_cmp    = resp_cmp_q;
    assign alu_op1         = alu_op1_q;
    assign alu_op2         = alu_op2_q;
    assign alu_instr       = alu_instr_q;
    assign busy            = (state_q != IDLE);

endmodule
